// File: rtl/ua_adc_rx_pkg.sv
// Shared definitions for the ADC receive datapath: FSM state codes, settle time
// and the lane-major to sample-major transpose.
package ua_adc_rx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_LOCKED = 3'd3;
  localparam logic [2:0] ST_FAIL   = 3'd4;

  localparam int SETTLE_CYCLES = 2;
  localparam int MAX_BITS      = 256;

  // Sample k, bit j of the result comes from lane j, time slot k of the raw word.
  function automatic logic [MAX_BITS-1:0] transpose(
    input logic [MAX_BITS-1:0] raw,
    input int                  lanes,
    input int                  ratio
  );
    logic [MAX_BITS-1:0] t;
    t = '0;
    for (int k = 0; k < ratio; k++) begin
      for (int j = 0; j < lanes; j++) begin
        t[k*lanes+j] = raw[j*ratio+k];
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/ua_adc_word_rotate.sv
// Two-word history of sample-major words and the sample rotation mux that
// realigns the word boundary by i_rot samples.
module ua_adc_word_rotate #(
  parameter int LANES = 10,
  parameter int RATIO = 4,
  parameter int RW    = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [LANES*RATIO-1:0] i_word,
  input  logic [RW-1:0]          i_rot,
  output logic [LANES*RATIO-1:0] o_word
);

  logic [LANES*RATIO-1:0]   r_w0;
  logic [LANES*RATIO-1:0]   r_w1;
  logic [2*LANES*RATIO-1:0] w_ext;

  // word history: r_w1 is the older word, r_w0 the one that follows it
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_w0 <= '0;
      r_w1 <= '0;
    end else begin
      r_w0 <= i_word;
      r_w1 <= r_w0;
    end
  end

  // Extended sequence e[0..2R-1]: older word in the low samples, so sample k+r
  // spills into the newer word once k+r reaches R.
  assign w_ext  = {r_w0, r_w1};
  assign o_word = w_ext[int'(i_rot)*LANES +: LANES*RATIO];

endmodule

// File: rtl/ua_adc_data_align.sv
// ADC receive alignment: transpose, word-boundary training against a fixed test
// pattern, delay-matched output pipeline and lock/fail status.
module ua_adc_data_align
  import ua_adc_rx_pkg::*;
#(
  parameter int              LANES      = 10,
  parameter int              RATIO      = 4,
  parameter int              PIPE_DEPTH = 3,
  parameter int              LOCK_COUNT = 16,
  parameter logic [LANES-1:0] TRAIN_BASE = 10'h155
) (
  input  logic                       i_clk_div,
  input  logic                       i_rst_n,
  input  logic [LANES*RATIO-1:0]     i_p_data,
  input  logic                       i_or_in,
  input  logic                       i_train_start,
  output logic [LANES*RATIO-1:0]     o_data,
  output logic                       o_data_or,
  output logic                       o_data_valid,
  output logic                       o_locked,
  output logic                       o_train_fail,
  output logic [$clog2(RATIO)-1:0]   o_slip_offset
);

  localparam int W  = LANES * RATIO;
  localparam int RW = $clog2(RATIO);
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int OD = PIPE_DEPTH + 2;

  function automatic logic [W-1:0] f_train_word();
    logic [W-1:0] t;
    t = '0;
    for (int k = 0; k < RATIO; k++) begin
      t[k*LANES +: LANES] = TRAIN_BASE + LANES'(k);
    end
    return t;
  endfunction

  localparam logic [W-1:0] TRAIN_WORD = f_train_word();

  logic [W-1:0]  w_sample;
  logic [W-1:0]  w_rot;
  logic          w_match;
  logic [W-1:0]  r_pipe [PIPE_DEPTH];
  logic [OD-1:0] r_or_sr;
  logic [2:0]    r_state;
  logic [1:0]    r_settle;
  logic [CW-1:0] r_count;
  logic [RW-1:0] r_rot;
  logic          r_locked;
  logic          r_fail;

  assign w_sample = W'(transpose(MAX_BITS'(i_p_data), LANES, RATIO));

  ua_adc_word_rotate #(
    .LANES (LANES),
    .RATIO (RATIO),
    .RW    (RW)
  ) u_rotate (
    .i_clk   (i_clk_div),
    .i_rst_n (i_rst_n),
    .i_word  (w_sample),
    .i_rot   (r_rot),
    .o_word  (w_rot)
  );

  // aligned-data pipeline and the or_in delay line that matches it
  always_ff @(posedge i_clk_div) begin
    if (!i_rst_n) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        r_pipe[i] <= '0;
      end
      r_or_sr <= '0;
    end else begin
      r_pipe[0] <= w_rot;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
      r_or_sr <= {r_or_sr[OD-2:0], i_or_in};
    end
  end

  assign w_match = (r_pipe[0] == TRAIN_WORD);

  // training FSM; train_start overrides any transition on the same edge
  always_ff @(posedge i_clk_div) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_settle <= 2'd0;
      r_count  <= '0;
      r_rot    <= '0;
      r_locked <= 1'b0;
      r_fail   <= 1'b0;
    end else if (i_train_start) begin
      r_state  <= ST_SETTLE;
      r_settle <= 2'd0;
      r_count  <= '0;
      r_rot    <= '0;
      r_locked <= 1'b0;
      r_fail   <= 1'b0;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          if (r_settle == 2'(SETTLE_CYCLES - 1)) begin
            r_settle <= 2'd0;
            r_state  <= ST_CHECK;
          end else begin
            r_settle <= r_settle + 2'd1;
          end
        end
        ST_CHECK: begin
          if (w_match) begin
            if (r_count == CW'(LOCK_COUNT - 1)) begin
              r_count  <= CW'(LOCK_COUNT);
              r_locked <= 1'b1;
              r_state  <= ST_LOCKED;
            end else begin
              r_count <= r_count + CW'(1);
            end
          end else begin
            r_count <= '0;
            if (r_rot == RW'(RATIO - 1)) begin
              r_rot   <= '0;
              r_fail  <= 1'b1;
              r_state <= ST_FAIL;
            end else begin
              r_rot   <= r_rot + RW'(1);
              r_state <= ST_SETTLE;
            end
          end
        end
        ST_IDLE, ST_LOCKED, ST_FAIL: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_data        = r_pipe[PIPE_DEPTH-1];
  assign o_data_or     = r_or_sr[OD-1];
  assign o_data_valid  = r_locked;
  assign o_locked      = r_locked;
  assign o_train_fail  = r_fail;
  assign o_slip_offset = r_rot;

endmodule

// File: tb/tb_ua_adc_data_align.sv
// Randomised self-checking bench for ua_adc_data_align against a sample-level
// reference model of the alignment rules.
module tb_ua_adc_data_align;

  logic        clk_div;
  logic        rst_n;
  logic [39:0] p_data;
  logic        or_in;
  logic        train_start;
  logic [39:0] data;
  logic        data_or;
  logic        data_valid;
  logic        locked;
  logic        train_fail;
  logic [1:0]  slip_offset;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int clean    = 0;
  int n_evt;
  int exp_r    = 0;
  bit chk_data = 0;
  int slip_log[$];
  logic [39:0] in_hist [1024];
  logic        or_hist [1024];

  ua_adc_data_align dut (
    .i_clk_div     (clk_div),
    .i_rst_n       (rst_n),
    .i_p_data      (p_data),
    .i_or_in       (or_in),
    .i_train_start (train_start),
    .o_data        (data),
    .o_data_or     (data_or),
    .o_data_valid  (data_valid),
    .o_locked      (locked),
    .o_train_fail  (train_fail),
    .o_slip_offset (slip_offset)
  );

  initial clk_div = 1'b0;
  always #5 clk_div = ~clk_div;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // value of time sample k across the 10 lanes of a raw lane-major word
  function automatic int sample_of(input logic [39:0] raw, input int k);
    int v;
    v = 0;
    for (int j = 0; j < 10; j++) v = v | (int'(raw[j*4+k]) << j);
    return v;
  endfunction

  // raw word whose sample k carries 0x155 + ((k+shift) mod 4)
  function automatic logic [39:0] pat_raw(input int shift);
    logic [39:0] raw;
    int v;
    raw = '0;
    for (int k = 0; k < 4; k++) begin
      v = 'h155 + ((k + shift) % 4);
      for (int j = 0; j < 10; j++) raw[j*4+k] = v[j];
    end
    return raw;
  endfunction

  function automatic logic [39:0] train_word();
    logic [39:0] w;
    for (int k = 0; k < 4; k++) w[k*10 +: 10] = 10'('h155 + k);
    return w;
  endfunction

  // aligned word: sample k = e[k+r], e = samples of older word then newer word
  function automatic logic [39:0] model_out(input logic [39:0] older, input logic [39:0] newer, input int r);
    int e[8];
    logic [39:0] w;
    for (int k = 0; k < 4; k++) begin
      e[k]   = sample_of(older, k);
      e[4+k] = sample_of(newer, k);
    end
    for (int k = 0; k < 4; k++) w[k*10 +: 10] = 10'(e[k+r]);
    return w;
  endfunction

  function automatic logic [39:0] rand40();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[39:0];
  endfunction

  task automatic step();
    @(posedge clk_div);
    cyc++;
    in_hist[cyc % 1024] = p_data;
    or_hist[cyc % 1024] = or_in;
    if (rst_n) clean++;
    else clean = 0;
    #1;
    if (clean >= 5) chk("data_or", data_or, or_hist[(cyc-4) % 1024]);
    if (chk_data && clean >= 5)
      chk("data", data, model_out(in_hist[(cyc-4) % 1024], in_hist[(cyc-3) % 1024], exp_r));
  endtask

  task automatic present(input int mode);
    p_data = (mode < 0) ? rand40() : pat_raw(mode);
    or_in  = 1'($urandom_range(0, 1));
  endtask

  task automatic prime_and_start(input int mode);
    repeat (5) begin present(mode); step(); end
    present(mode);
    train_start = 1'b1;
    step();
    train_start = 1'b0;
  endtask

  task automatic train(input int mode, input int budget);
    int last;
    prime_and_start(mode);
    slip_log.delete();
    last = 0;
    n_evt = -1;
    for (int n = 1; n <= budget; n++) begin
      present(mode);
      step();
      if (int'(slip_offset) != last) begin
        last = int'(slip_offset);
        slip_log.push_back(last);
      end
      if (locked || train_fail) begin
        n_evt = n;
        break;
      end
    end
    if (n_evt < 0) chk("train_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; train_start = 1'b0; p_data = '0; or_in = 1'b0;
    p_data = rand40();
    repeat (3) step();
    chk("rst_data", data, 40'd0);
    chk("rst_data_or", data_or, 1'b0);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_fail", train_fail, 1'b0);
    chk("rst_slip", slip_offset, 2'd0);
    rst_n = 1'b1;

    // aligned stream: 2 settle + 16 checks
    train(0, 100);
    chk("al_lock_cycle", n_evt, 18);
    chk("al_locked", locked, 1'b1);
    chk("al_valid", data_valid, 1'b1);
    chk("al_fail", train_fail, 1'b0);
    chk("al_slip", slip_offset, 2'd0);
    chk("al_slip_steps", slip_log.size(), 0);
    exp_r = 0; chk_data = 1;
    repeat (8) begin present(0); step(); end
    chk("al_word", data, train_word());
    chk_data = 0;

    // stream shifted by two samples
    train(2, 100);
    chk("sh_steps", slip_log.size(), 2);
    if (slip_log.size() == 2) begin
      chk("sh_step0", slip_log[0], 1);
      chk("sh_step1", slip_log[1], 2);
    end
    chk("sh_lock_cycle", n_evt, 24);
    chk("sh_locked", locked, 1'b1);
    chk("sh_slip", slip_offset, 2'd2);
    exp_r = 2; chk_data = 1;
    repeat (8) begin present(2); step(); end
    chk("sh_word", data, train_word());
    chk_data = 0;

    // random data exhausts all offsets
    train(-1, 60);
    chk("rn_fail_cycle", n_evt, 12);
    chk("rn_fail", train_fail, 1'b1);
    chk("rn_locked", locked, 1'b0);
    chk("rn_slip", slip_offset, 2'd0);
    chk("rn_steps", slip_log.size(), 4);
    train(0, 100);
    chk("rn_relock_cycle", n_evt, 18);
    chk("rn_relock", locked, 1'b1);
    chk("rn_relock_fail", train_fail, 1'b0);

    // latency and bit mapping with r=0 (locked)
    exp_r = 0; chk_data = 1;
    for (int m = 0; m < 4; m++) begin
      int j, k;
      logic [39:0] mk;
      logic [39:0] ex;
      j = (m == 0) ? 0 : (m == 1) ? 9 : (m == 2) ? 4 : 7;
      k = (m == 0) ? 0 : (m == 1) ? 3 : (m == 2) ? 1 : 2;
      repeat (6) begin p_data = '0; or_in = 1'b0; step(); end
      mk = '0; mk[j*4+k] = 1'b1;
      p_data = mk; or_in = 1'b1;
      step();
      p_data = '0; or_in = 1'b0;
      repeat (3) step();
      chk("lat_or_early", data_or, 1'b0);
      step();
      ex = '0; ex[k*10+j] = 1'b1;
      chk("lat_or", data_or, 1'b1);
      chk("lat_marker", data, ex);
    end
    chk_data = 0;

    // one corrupted word while the match count is 10
    prime_and_start(0);
    for (int n = 1; n <= 13; n++) begin
      present(0);
      if (n == 10) p_data = p_data ^ 40'h1;
      step();
      if (n == 12) begin
        chk("cr_slip_pre", slip_offset, 2'd0);
        chk("cr_locked_pre", locked, 1'b0);
      end
      if (n == 13) begin
        chk("cr_slip", slip_offset, 2'd1);
        chk("cr_locked", locked, 1'b0);
      end
    end

    // reset while checking at r=2
    prime_and_start(-1);
    for (int n = 1; n <= 8; n++) begin present(-1); step(); end
    chk("mr_slip_pre", slip_offset, 2'd2);
    present(-1);
    rst_n = 1'b0;
    step();
    chk("mr_data", data, 40'd0);
    chk("mr_data_or", data_or, 1'b0);
    chk("mr_valid", data_valid, 1'b0);
    chk("mr_locked", locked, 1'b0);
    chk("mr_fail", train_fail, 1'b0);
    chk("mr_slip", slip_offset, 2'd0);
    rst_n = 1'b1;
    repeat (25) begin present(0); step(); end
    chk("mr_idle_locked", locked, 1'b0);
    chk("mr_idle_fail", train_fail, 1'b0);

    // train_start on the edge that would lock
    prime_and_start(0);
    for (int n = 1; n <= 18; n++) begin
      present(0);
      if (n == 18) train_start = 1'b1;
      step();
      train_start = 1'b0;
    end
    chk("se_locked", locked, 1'b0);
    chk("se_slip", slip_offset, 2'd0);
    chk("se_fail", train_fail, 1'b0);
    for (int n = 1; n <= 18; n++) begin
      present(0);
      step();
      if (n == 17) chk("se_locked_early", locked, 1'b0);
      if (n == 18) chk("se_relock", locked, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
